fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch front-end with prefetch buffering. Sits between the instruction ROM and the decode stage.
- Generates sequential fetch PCs and issues one imem read per cycle.
- Stores returned {pc, instr} pairs in a DEPTH-entry FIFO.
- Presents the FIFO head to decode with a valid/ready handshake.
- Decode stalls or fetch-side ROM latency no longer freeze PC generation; branch/jump redirects flush all buffered and in-flight fetches.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
RESET_PC, 64'h0, first fetch address after reset.
XLEN, 64, PC width.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  read request to instruction ROM this cycle.
imem_addr  out  XLEN  byte address of the request; bits [1:0] always 0.
imem_rdata  in  32  ROM data; valid exactly one cycle after imem_req.
redirect_valid  in  1  taken branch/jump/trap from execute; flush and restart.
redirect_pc  in  XLEN  restart address; bits [1:0] ignored and forced to 0.
out_valid  out  1  head entry available to decode.
out_ready  in  1  decode accepts head this cycle.
out_pc  out  XLEN  PC of head entry.
out_instr  out  32  instruction of head entry.
count  out  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc <= RESET_PC; count <= 0; rd/wr pointers <= 0; inflight <= 0.
  - While rst is high: imem_req=0, out_valid=0, out_pc=0, out_instr=0.
  - Reset mid-operation discards all entries and the in-flight response, identically to a redirect to RESET_PC.
- Issue rule: imem_req=1 when !rst && !redirect_valid && (count + inflight - pop) < DEPTH.
  - pop = out_valid && out_ready.
  - imem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 4, wrapping modulo 2^XLEN; inflight <= 1. Otherwise inflight <= 0.
- Response: in the cycle after an issue, imem_rdata is written with its PC at the write pointer (push), unless flushed.
- Latency (reset released at cycle 0): req at cycle 0, push at end of cycle 1, out_valid=1 in cycle 2.
- Pop: when out_valid && out_ready, the read pointer advances and count decrements.
- Simultaneous push and pop: count is unchanged. This is legal at count=DEPTH because the issue rule already reserved the slot.
- Full (count=DEPTH):
  - No issue.
  - Head held stable: out_pc and out_instr must not change while out_valid && !out_ready.
- Empty: out_valid=0. out_pc and out_instr hold their last value, and decode must ignore them.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows; assertions are required in the bench.
- Redirect (redirect_valid=1 at posedge):
  - count <= 0; pointers <= 0.
  - The in-flight response arriving next cycle is dropped.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - No issue in the redirect cycle; the first new request is the following cycle.
- Priority: rst > redirect_valid > push/pop. A pop in the redirect cycle is ignored for state update; decode still sees out_valid that cycle and is responsible for squashing it.
- No combinational path from out_ready to out_valid, out_pc or out_instr.

Optional Feature:
FETCH_QUEUE_BYPASS_EN.
- Defined: when the queue is empty and a non-flushed response arrives, out_valid=1 in the same cycle, with out_instr=imem_rdata and out_pc equal to the pending PC.
  - If out_ready=1, the entry is consumed without being written (count stays 0).
  - Otherwise it is written normally.
  - First-instruction latency drops to 1 cycle after the request.
- Undefined: no bypass; head is always taken from FIFO storage, with latency as stated above.

Test Plan:
- Reset release, out_ready=1, ROM word n = 32'h00000013+n:
  - out_pc sequence 0x0, 0x4, 0x8, ...; first out_valid in cycle 2, or cycle 1 with bypass.
  - One instruction per cycle thereafter.
- out_ready=0 for 10 cycles after reset:
  - count saturates at DEPTH=4 and imem_req drops to 0.
  - Head stays pc=0x0, instr=0x00000013.
  - On out_ready=1, pops 0x0..0xC in order with no gap or duplicate.
- Redirect with redirect_pc=0x103, queue holding 3 entries and a request in flight:
  - Next cycle count=0 and the in-flight word is dropped.
  - Next imem_addr=0x100; first out_pc=0x100.
- Full queue with simultaneous pop and arriving push:
  - count stays 4; order preserved across pointer wrap; checked over 20 cycles with random out_ready.
- rst asserted for one cycle while count=3:
  - Next cycle out_valid=0, count=0, imem_addr=RESET_PC; stale in-flight data never appears on out_instr.
- redirect_valid and out_ready high in the same cycle with count=2:
  - count=0 after the edge; fetch restarts at redirect_pc; no underflow assertion fires.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: sequential PC generation, one-cycle ROM reads,
// DEPTH-entry {pc, instr} prefetch FIFO. Optional same-cycle bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned OW = CW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] hold_pc;
  logic [31:0]     hold_instr;
  logic            inflight;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];

  logic          resp;
  logic          stored;
  logic          bypass_hit;
  logic          head_valid;
  logic          pop;
  logic          push;
  logic          fifo_pop;
  logic          issue;
  logic [OW-1:0] occupancy;

  // A response is only live when neither reset nor a redirect flushes it.
  assign resp   = inflight && !rst && !redirect_valid;
  assign stored = (cnt != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass_hit = resp && !stored;
`else
  assign bypass_hit = 1'b0;
`endif

  assign head_valid = !rst && (stored || bypass_hit);
  assign pop        = head_valid && out_ready;
  assign push       = resp && !(bypass_hit && out_ready);
  assign fifo_pop   = pop && stored;

  // Slots already claimed (stored + in flight) minus what leaves this cycle.
  assign occupancy = OW'(cnt) + OW'(inflight) - OW'(pop);
  assign issue     = !rst && !redirect_valid && (occupancy < OW'(DEPTH));

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign out_valid = head_valid;
  assign count     = cnt;

  always_comb begin
    out_pc    = hold_pc;
    out_instr = hold_instr;
    if (rst) begin
      out_pc    = '0;
      out_instr = '0;
    end else if (stored) begin
      out_pc    = mem_pc[rd_ptr];
      out_instr = mem_instr[rd_ptr];
    end else if (bypass_hit) begin
      out_pc    = pend_pc;
      out_instr = imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      cnt      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        pend_pc  <= fetch_pc;
      end
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (fifo_pop)
        rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= pend_pc;
      mem_instr[wr_ptr] <= imem_rdata;
    end
  end

  // Last presented head, shown again while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_pc    <= '0;
      hold_instr <= '0;
    end else if (head_valid) begin
      hold_pc    <= out_pc;
      hold_instr <= out_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: latency, back-pressure, redirect, reset and
// order under random out_ready, against a one-cycle ROM model.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.DEPTH(4), .XLEN(64), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: word at byte address a is 0x13 + a/4, returned one cycle after the request.
  always @(posedge clk)
    imem_rdata <= imem_req ? (32'h13 + imem_addr[33:2]) : 32'hdead_beef;

  always @(negedge clk)
    if (!rst) cnt_bound: assert (count <= 3'd4)
      else $error("FAIL cnt_bound count=%0d max=4", count);

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  bit first_reset = 1'b1;

  // Leaves the bench 1 time unit into cycle 0 (first cycle with rst low).
  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    next();
    if (first_reset) begin
      #1;
      chk("rst_req",   64'(imem_req),  64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_pc",    out_pc,         64'd0);
      chk("rst_instr", 64'(out_instr), 64'd0);
      chk("rst_count", 64'(count),     64'd0);
      first_reset = 1'b0;
    end
    next();
    rst = 1'b0;
  endtask

  int m_count, m_infl, m_fpc, exp_pc, m_pop, m_issue, m_push, exp_v;

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;

    // Streaming with decode always ready.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("t1_req%0d", k),   64'(imem_req),  64'd1);
      chk($sformatf("t1_addr%0d", k),  imem_addr,      64'(4 * k));
      chk($sformatf("t1_valid%0d", k), 64'(out_valid), 64'(k >= LAT));
      chk($sformatf("t1_count%0d", k), 64'(count),     64'((!BYP && k >= 2) ? 1 : 0));
      if (k >= LAT) begin
        chk($sformatf("t1_pc%0d", k),    out_pc,         64'(4 * (k - LAT)));
        chk($sformatf("t1_instr%0d", k), 64'(out_instr), 64'(32'h13 + k - LAT));
      end
      next();
    end

    // Back-pressure for 10 cycles, then drain.
    do_reset();
    for (int k = 0; k < 18; k++) begin
      out_ready = (k >= 10);
      #1;
      if (k < 4) begin
        chk($sformatf("t2_req%0d", k),  64'(imem_req), 64'd1);
        chk($sformatf("t2_addr%0d", k), imem_addr,     64'(4 * k));
      end else if (k < 10) begin
        chk($sformatf("t2_req%0d", k),   64'(imem_req),  64'd0);
        chk($sformatf("t2_count%0d", k), 64'(count),     64'(k == 4 ? 3 : 4));
        chk($sformatf("t2_valid%0d", k), 64'(out_valid), 64'd1);
        chk($sformatf("t2_hpc%0d", k),   out_pc,         64'd0);
        chk($sformatf("t2_hins%0d", k),  64'(out_instr), 64'h13);
      end else begin
        chk($sformatf("t2_valid%0d", k), 64'(out_valid), 64'd1);
        chk($sformatf("t2_pc%0d", k),    out_pc,         64'(4 * (k - 10)));
        chk($sformatf("t2_instr%0d", k), 64'(out_instr), 64'(32'h13 + k - 10));
      end
      next();
    end

    // Redirect with three entries stored and one response arriving.
    do_reset();
    for (int k = 0; k < 4; k++) next();
    redirect_valid = 1'b1; redirect_pc = 64'h103;
    #1;
    chk("t3_pre_count", 64'(count),    64'd3);
    chk("t3_rd_req",    64'(imem_req), 64'd0);
    next();
    redirect_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("t3_count", 64'(count),     64'd0);
    chk("t3_valid", 64'(out_valid), 64'd0);
    chk("t3_req",   64'(imem_req),  64'd1);
    chk("t3_addr",  imem_addr,      64'h100);
    for (int j = 1; j <= LAT + 1; j++) begin
      next(); #1;
      chk($sformatf("t3_valid%0d", j), 64'(out_valid), 64'(j >= LAT));
      if (j >= LAT) begin
        chk($sformatf("t3_pc%0d", j),    out_pc,         64'(32'h100 + 4 * (j - LAT)));
        chk($sformatf("t3_instr%0d", j), 64'(out_instr), 64'(32'h53 + j - LAT));
      end
    end

    // From full, random out_ready against a small occupancy/order model.
    do_reset();
    for (int k = 0; k < 6; k++) next();
    m_count = 4; m_infl = 0; m_fpc = 'h10; exp_pc = 0;
    for (int k = 0; k < 20; k++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      exp_v = (m_count != 0 || (BYP && m_infl != 0)) ? 1 : 0;
      chk($sformatf("t4_valid%0d", k), 64'(out_valid), 64'(exp_v));
      chk($sformatf("t4_count%0d", k), 64'(count),     64'(m_count));
      m_pop   = (exp_v != 0 && out_ready) ? 1 : 0;
      m_issue = (m_count + m_infl - m_pop < 4) ? 1 : 0;
      chk($sformatf("t4_req%0d", k), 64'(imem_req), 64'(m_issue));
      if (m_issue != 0)
        chk($sformatf("t4_addr%0d", k), imem_addr, 64'(m_fpc));
      if (m_pop != 0) begin
        chk($sformatf("t4_pc%0d", k),    out_pc,         64'(exp_pc));
        chk($sformatf("t4_instr%0d", k), 64'(out_instr), 64'(32'h13 + exp_pc / 4));
        exp_pc += 4;
      end
      m_push  = (m_infl != 0 && !(BYP && m_count == 0 && out_ready)) ? 1 : 0;
      m_count = m_count + m_push - ((m_pop != 0 && m_count != 0) ? 1 : 0);
      m_infl  = m_issue;
      if (m_issue != 0) m_fpc += 4;
      next();
    end

    // One-cycle reset with three entries stored and a response arriving.
    do_reset();
    for (int k = 0; k < 4; k++) next();
    #1;
    chk("t5_pre_count", 64'(count), 64'd3);
    rst = 1'b1;
    #1;
    chk("t5_rst_req",   64'(imem_req),  64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    chk("t5_rst_pc",    out_pc,         64'd0);
    chk("t5_rst_instr", 64'(out_instr), 64'd0);
    next();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_count", 64'(count),     64'd0);
    chk("t5_req",   64'(imem_req),  64'd1);
    chk("t5_addr",  imem_addr,      64'h0);
    for (int j = 1; j <= LAT; j++) begin
      next(); #1;
      chk($sformatf("t5_valid%0d", j), 64'(out_valid), 64'(j >= LAT));
      if (j >= LAT) begin
        chk("t5_pc",    out_pc,         64'h0);
        chk("t5_instr", 64'(out_instr), 64'h13);
      end
    end

    // Redirect and pop in the same cycle with two entries stored.
    do_reset();
    for (int k = 0; k < 3; k++) next();
    redirect_valid = 1'b1; redirect_pc = 64'h200; out_ready = 1'b1;
    #1;
    chk("t6_pre_count", 64'(count),     64'd2);
    chk("t6_rd_valid",  64'(out_valid), 64'd1);
    chk("t6_rd_pc",     out_pc,         64'h0);
    chk("t6_rd_req",    64'(imem_req),  64'd0);
    next();
    redirect_valid = 1'b0;
    #1;
    chk("t6_count", 64'(count),     64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_req",   64'(imem_req),  64'd1);
    chk("t6_addr",  imem_addr,      64'h200);
    for (int j = 1; j <= LAT + 1; j++) begin
      next(); #1;
      chk($sformatf("t6_valid%0d", j), 64'(out_valid), 64'(j >= LAT));
      if (j >= LAT) begin
        chk($sformatf("t6_pc%0d", j),    out_pc,         64'(32'h200 + 4 * (j - LAT)));
        chk($sformatf("t6_instr%0d", j), 64'(out_instr), 64'(32'h93 + j - LAT));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
